// File: rtl/axis_master.sv
// AXI4-Stream packet master: a user-filled FIFO drained into fixed-length packets.
// Optional completed-packet counter port enabled by defining AXIS_MASTER_PKT_CNT_EN.
module axis_master #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              m_axis_aclk,
   input  logic              m_axis_arstn,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   input  logic              start,
   input  logic [3:0]        pkt_len,
   output logic              busy,
`ifdef AXIS_MASTER_PKT_CNT_EN
   output logic [15:0]       pkt_count,
`endif
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {StIdle, StRun, StLast} state_e;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [4:0]        remaining_q, remaining_d;
   state_e            state_q, state_d;
   logic [DATA_W-1:0] tdata_q, tdata_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;

   logic push, pop, empty, slot_free, handshake;

   // Full is judged on the registered count, so a write is dropped even if a pop
   // frees a slot at the same edge.
   assign full      = (cnt_q == CW'(DEPTH));
   assign empty     = (cnt_q == '0);
   assign push      = wr_en & ~full;
   assign slot_free = ~tvalid_q | m_axis_tready;
   assign handshake = tvalid_q & m_axis_tready;

   assign busy          = (state_q != StIdle);
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;

   // Storage carries no reset; emptiness is defined by the pointers and count.
   always_ff @(posedge m_axis_aclk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      tdata_d     = tdata_q;
      tvalid_d    = tvalid_q;
      tlast_d     = tlast_q;
      pop         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               remaining_d = {1'b0, pkt_len} + 5'd1;
               state_d     = StRun;
            end
         end
         StRun: begin
            if (slot_free && !empty) begin
               pop         = 1'b1;
               tdata_d     = mem_q[rd_ptr_q];
               tvalid_d    = 1'b1;
               tlast_d     = (remaining_q == 5'd1);
               remaining_d = remaining_q - 5'd1;
               if (remaining_q == 5'd1) begin
                  state_d = StLast;
               end
            end else if (handshake) begin
               // Beat accepted but nothing to replace it with: insert a bubble.
               tvalid_d = 1'b0;
            end
         end
         StLast: begin
            if (handshake) begin
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_arstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         state_q     <= StIdle;
         remaining_q <= '0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         remaining_q <= remaining_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         tlast_q     <= tlast_d;
      end
   end

`ifdef AXIS_MASTER_PKT_CNT_EN
   logic [15:0] pkt_count_q;

   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_arstn) begin
         pkt_count_q <= '0;
      end else if (state_q == StLast && handshake) begin
         pkt_count_q <= pkt_count_q + 16'd1;
      end
   end

   assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_axis_master.sv
// Self-checking bench for axis_master: directed scenarios plus a randomized phase,
// scored against a queue-based model of accepted writes and packet boundaries.
module tb_axis_master;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       arstn, wr_en, start, tready;
   logic [7:0] wr_data;
   logic [3:0] pkt_len;
   logic       full, busy, tvalid, tlast;
   logic [7:0] tdata;
`ifdef AXIS_MASTER_PKT_CNT_EN
   logic [15:0] pkt_count;
`endif

   always #5 clk = ~clk;

   axis_master #(
      .DATA_W(8),
      .DEPTH (DEPTH)
   ) dut (
      .m_axis_aclk  (clk),
      .m_axis_arstn (arstn),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .start        (start),
      .pkt_len      (pkt_len),
      .busy         (busy),
`ifdef AXIS_MASTER_PKT_CNT_EN
      .pkt_count    (pkt_count),
`endif
      .m_axis_tdata (tdata),
      .m_axis_tvalid(tvalid),
      .m_axis_tlast (tlast),
      .m_axis_tready(tready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: every accepted, not-yet-handshaken byte in order, plus packet progress.
   logic [7:0] exp_q[$];
   bit         pkt_act   = 1'b0;
   int         pkt_beats = 0;
   int         beat_idx  = 0;
   int         hs_count  = 0;
   int         model_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge with model update; outputs sampled 1 time unit after the edge.
   task automatic cycle();
      bit         p_rst, p_valid, p_ready, p_last, p_full, p_we, p_start, was_act, acc;
      logic [7:0] p_data, p_wd, e;
      logic [3:0] p_len;
      int         occ;
      p_rst   = arstn;
      p_valid = tvalid;
      p_ready = tready;
      p_last  = tlast;
      p_full  = full;
      p_data  = tdata;
      p_we    = wr_en;
      p_wd    = wr_data;
      p_start = start;
      p_len   = pkt_len;
      if (p_rst) begin
         occ = exp_q.size() - (p_valid ? 1 : 0);
         chk("full_flag", 32'(p_full), 32'(occ == DEPTH));
         acc     = p_we && (occ < DEPTH);
         was_act = pkt_act;
         if (p_valid && p_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'(p_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("tdata", 32'(p_data), 32'(e));
            end
            chk("tlast", 32'(p_last), 32'(pkt_act && beat_idx == pkt_beats - 1));
            beat_idx++;
            hs_count++;
            if (beat_idx >= pkt_beats) begin
               pkt_act = 1'b0;
               model_cnt++;
            end
         end
         if (!was_act && p_start) begin
            pkt_act   = 1'b1;
            pkt_beats = int'(p_len) + 1;
            beat_idx  = 0;
         end
         if (acc) exp_q.push_back(p_wd);
      end
      @(posedge clk);
      #1;
      if (!p_rst) begin
         exp_q.delete();
         pkt_act   = 1'b0;
         beat_idx  = 0;
         model_cnt = 0;
         chk("rst_tvalid", 32'(tvalid), 32'd0);
         chk("rst_tlast", 32'(tlast), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_full", 32'(full), 32'd0);
         chk("rst_tdata", 32'(tdata), 32'd0);
      end else begin
         if (p_valid && !p_ready) begin
            chk("stall_tvalid", 32'(tvalid), 32'd1);
            chk("stall_tdata", 32'(tdata), 32'(p_data));
            chk("stall_tlast", 32'(tlast), 32'(p_last));
         end
         chk("busy", 32'(busy), 32'(pkt_act));
      end
`ifdef AXIS_MASTER_PKT_CNT_EN
      chk("pkt_count", 32'(pkt_count), 32'(model_cnt & 16'hFFFF));
`endif
   endtask

   task automatic write_byte(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      cycle();
      wr_en   = 1'b0;
   endtask

   task automatic start_pkt(input logic [3:0] len);
      start   = 1'b1;
      pkt_len = len;
      cycle();
      start   = 1'b0;
   endtask

   task automatic wait_idle(input int bound, input string tag);
      int n = 0;
      while (busy && n < bound) begin
         cycle();
         n++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      int n, hs0, bubbles;
      bit seen_valid;
      arstn   = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      start   = 1'b0;
      pkt_len = '0;
      tready  = 1'b0;
      repeat (10) cycle();
      arstn = 1'b1;

      // Scenario 1: preloaded FIFO, full-rate 10-beat packet.
      for (int i = 0; i < 10; i++) write_byte(8'h11 + 8'(i));
      tready = 1'b1;
      hs0    = hs_count;
      start_pkt(4'd9);
      n = 0;
      while (busy && n < 100) begin
         cycle();
         n++;
      end
      chk("s1_cycles", 32'(n), 32'd11);
      chk("s1_beats", 32'(hs_count - hs0), 32'd10);

      // Scenario 2: tready toggling.
      for (int i = 0; i < 10; i++) write_byte(8'h11 + 8'(i));
      hs0 = hs_count;
      start_pkt(4'd9);
      n = 0;
      while (busy && n < 200) begin
         tready = ~tready;
         cycle();
         n++;
      end
      chk("s2_idle", 32'(busy), 32'd0);
      chk("s2_beats", 32'(hs_count - hs0), 32'd10);

      // Scenario 3: packet started on an empty FIFO, data trickles in.
      tready     = 1'b1;
      hs0        = hs_count;
      bubbles    = 0;
      seen_valid = 1'b0;
      start_pkt(4'd3);
      for (int c = 0; c < 12; c++) begin
         wr_en   = (c % 3 == 0);
         wr_data = 8'hA0 + 8'(c / 3);
         cycle();
         if (seen_valid && busy && !tvalid) bubbles++;
         if (tvalid) seen_valid = 1'b1;
      end
      wr_en = 1'b0;
      wait_idle(50, "s3_idle");
      chk("s3_bubble", 32'(bubbles > 0), 32'd1);
      chk("s3_beats", 32'(hs_count - hs0), 32'd4);

      // Scenario 4: overflow drops, including a write at the first pop edge.
      for (int i = 0; i < 16; i++) write_byte(8'($urandom_range(0, 254)));
      chk("s4_full", 32'(full), 32'd1);
      write_byte(8'hFF);
      chk("s4_full_hold", 32'(full), 32'd1);
      hs0     = hs_count;
      wr_en   = 1'b1;
      wr_data = 8'hFF;
      start_pkt(4'd15);
      cycle();
      wr_en = 1'b0;
      wait_idle(100, "s4_idle");
      chk("s4_beats", 32'(hs_count - hs0), 32'd16);
      start_pkt(4'd0);
      repeat (4) cycle();
      chk("s4_fifo_empty", 32'(tvalid), 32'd0);
      write_byte(8'h3C);
      wait_idle(20, "s4_tail_idle");

      // Scenario 5: reset after the third beat of a 10-beat packet.
      for (int i = 0; i < 10; i++) write_byte(8'h50 + 8'(i));
      hs0 = hs_count;
      start_pkt(4'd9);
      n = 0;
      while ((hs_count - hs0) < 3 && n < 50) begin
         cycle();
         n++;
      end
      chk("s5_three_beats", 32'(hs_count - hs0), 32'd3);
      arstn = 1'b0;
      cycle();
      arstn = 1'b1;
      start_pkt(4'd0);
      repeat (4) cycle();
      chk("s5_fifo_empty", 32'(tvalid), 32'd0);
      hs0 = hs_count;
      write_byte(8'h5A);
      wait_idle(20, "s5_idle");
      chk("s5_beats", 32'(hs_count - hs0), 32'd1);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         wr_en   = ($urandom_range(0, 3) != 0);
         wr_data = 8'($urandom);
         start   = ($urandom_range(0, 7) == 0);
         pkt_len = 4'($urandom);
         tready  = ($urandom_range(0, 3) != 0);
         cycle();
      end
      start  = 1'b0;
      tready = 1'b1;
      n = 0;
      while (busy && n < 500) begin
         wr_en   = 1'b1;
         wr_data = 8'($urandom);
         cycle();
         n++;
      end
      wr_en = 1'b0;
      chk("rand_idle", 32'(busy), 32'd0);

      // Scenario 6: two packets after reset.
      arstn = 1'b0;
      cycle();
      arstn = 1'b1;
      for (int i = 0; i < 7; i++) write_byte(8'h70 + 8'(i));
      start_pkt(4'd1);
      wait_idle(20, "s6_idle_a");
      start_pkt(4'd4);
      wait_idle(20, "s6_idle_b");
`ifdef AXIS_MASTER_PKT_CNT_EN
      chk("s6_pkt_count", 32'(pkt_count), 32'd2);
`endif
      chk("s6_full", 32'(full), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_master.md
AXIS_MASTER -- requirements
Module: axis_master

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, tdata and wr_data width in bits.
REQ-002 SHALL provide parameter DEPTH, default 16, input FIFO depth in entries; must be a power of 2 and at least 2.
REQ-003 SHALL provide port m_axis_aclk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL provide port m_axis_arstn, input, 1, one clock, reset synchronous and active-low.
REQ-005 SHALL provide port wr_en, input, 1, user write strobe into the FIFO.
REQ-006 SHALL provide port wr_data, input, DATA_W, user write data.
REQ-007 SHALL provide port full, output, 1, FIFO holds DEPTH entries.
REQ-008 SHALL provide port start, input, 1, request to begin a packet.
REQ-009 SHALL provide port pkt_len, input, 4, packet length minus one; a packet is pkt_len+1 beats (1..16).
REQ-010 SHALL provide port busy, output, 1, packet in progress.
REQ-011 SHALL provide port m_axis_tdata, output, DATA_W, stream data.
REQ-012 SHALL provide port m_axis_tvalid, output, 1, stream valid.
REQ-013 SHALL provide port m_axis_tlast, output, 1, final beat of the packet.
REQ-014 SHALL provide port m_axis_tready, input, 1, downstream ready.
REQ-015 SHALL provide port pkt_count, output, 16, completed-packet count; present only when AXIS_MASTER_PKT_CNT_EN is defined.

Function
REQ-016 SHALL write wr_data into the FIFO at an edge where wr_en=1 and full=0; a write with full=1 SHALL be dropped, judged on pre-edge full even if a pop occurs at the same edge.
REQ-017 SHALL assert full combinationally from the current count (count==DEPTH); pointers wrap modulo DEPTH.
REQ-018 SHALL implement FSM states IDLE, RUN and LAST; busy=1 in RUN and LAST.
REQ-019 IDLE: an edge with start=1 SHALL latch remaining=pkt_len+1 and enter RUN; start while busy SHALL be ignored.
REQ-020 RUN: SHALL pop the FIFO into the output register at an edge where the output slot is free (tvalid=0 or tready=1) and the FIFO is non-empty; remaining decrements per pop.
REQ-021 The pop with remaining==1 SHALL set m_axis_tlast=1 with that beat and enter LAST; no further pops occur in LAST.
REQ-022 LAST: the edge where tvalid=1 and tready=1 SHALL clear tvalid and tlast and return to IDLE.
REQ-023 In RUN, a handshake at an edge with the FIFO empty SHALL clear tvalid (bubble); tlast SHALL never assert on a non-final beat.
REQ-024 While tvalid=1 and tready=0, tdata, tlast and tvalid SHALL hold stable.
REQ-025 Latency: start sampled at edge k, first pop no earlier than edge k+1, tvalid high after k+1; back-to-back beats at full rate while tready=1 and FIFO non-empty.
REQ-026 Data SHALL leave in FIFO order; none lost or duplicated.

Reset
REQ-027 At an edge with m_axis_arstn=0: state=IDLE, FIFO empty (pointers, count=0), full=0, busy=0, tvalid=0, tlast=0, tdata=0, remaining=0, pkt_count=0.
REQ-028 Reset mid-packet SHALL discard the in-flight beat and all FIFO contents, with no tlast emitted.

Configuration
REQ-029 With macro AXIS_MASTER_PKT_CNT_EN defined, pkt_count SHALL increment by 1 at each tlast handshake, wrapping 0xFFFF->0; when the macro is undefined, the port and counter SHALL be absent and behaviour is otherwise identical.

Verification
REQ-030 Scenario 1: reset 10 cycles, write 0x11..0x1A, start pkt_len=9, tready=1 -> 10 consecutive beats 0x11..0x1A, tlast only on 0x1A, then busy=0.
REQ-031 Scenario 2: same data, tready toggling 1,0,1,0 -> tdata/tvalid stable in stall cycles, 10 beats in order, no loss.
REQ-032 Scenario 3: start pkt_len=3 with FIFO empty, then write 0xA0..0xA3 at 3-cycle intervals -> tvalid low between beats, tlast on 0xA3.
REQ-033 Scenario 4: write 16 bytes with no start -> full=1; 17th write 0xFF dropped; a write with start active and pop at the same edge while full is also dropped; a later 16-beat packet contains no 0xFF.
REQ-034 Scenario 5: arstn=0 after the 3rd beat of a 10-beat packet -> next edge tvalid=0, tlast=0, busy=0, full=0, FIFO empty.
REQ-035 Scenario 6 (macro defined): two packets, pkt_len=1 and pkt_len=4 -> pkt_count=2; build without the macro -> port absent, Scenarios 1-5 pass.
